// File: rtl/coreresetp_ltssm_monitor.sv
// coreresetp_ltssm_monitor: debounces the LTSSM state carried on SDIF prdata[30:26] and flags state entries.
module coreresetp_ltssm_monitor #(
    parameter int unsigned STABLE_CNT = 3,
    parameter logic [4:0]  LTSSM_L0   = 5'b01111
) (
    input  logic        CLK_LTSSM,
    input  logic        sdif_core_reset_n_0,
    input  logic        psel,
    input  logic        pwrite,
    input  logic [31:0] prdata,
    output logic [4:0]  ltssm_state,
    output logic        state_change_p,
    output logic        hotreset_entry_p,
    output logic        disabled_entry_p,
    output logic        detectquiet_entry_p,
    output logic        l0_entry_p,
    output logic        link_up,
    output logic [7:0]  hotreset_count
);
    localparam logic [4:0] HOTRESET    = 5'b10100;
    localparam logic [4:0] DISABLED    = 5'b10000;
    localparam logic [4:0] DETECTQUIET = 5'b00000;
    localparam logic [3:0] CNT_MAX     = 4'(STABLE_CNT);

    logic [1:0] r_rst_sync;
    logic       w_rst_s;
    logic [4:0] r_ltssm_m, r_ltssm_s;
    logic       r_psel_m, r_psel_s, r_pwrite_m, r_pwrite_s;
    logic [4:0] r_cand;
    logic [3:0] r_cnt;
    logic       w_valid, w_match, w_commit;
    logic       w_unused;

    assign w_unused = ^{prdata[31], prdata[25:0]};

    always_ff @(posedge CLK_LTSSM or negedge sdif_core_reset_n_0)
        if (!sdif_core_reset_n_0)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};

    assign w_rst_s = r_rst_sync[1];

    always_ff @(posedge CLK_LTSSM or negedge w_rst_s)
        if (!w_rst_s) begin
            r_ltssm_m  <= '0;
            r_ltssm_s  <= '0;
            r_psel_m   <= 1'b0;
            r_psel_s   <= 1'b0;
            r_pwrite_m <= 1'b0;
            r_pwrite_s <= 1'b0;
        end else begin
            r_ltssm_m  <= prdata[30:26];
            r_ltssm_s  <= r_ltssm_m;
            r_psel_m   <= psel;
            r_psel_s   <= r_psel_m;
            r_pwrite_m <= pwrite;
            r_pwrite_s <= r_pwrite_m;
        end

    // prdata only carries the LTSSM code when no APB read is in flight
    assign w_valid  = !r_psel_s | r_pwrite_s;
    assign w_match  = r_ltssm_s == r_cand;
    assign w_commit = w_valid && w_match && (r_cnt == CNT_MAX - 4'd1) && (r_cand != ltssm_state);

    always_ff @(posedge CLK_LTSSM or negedge w_rst_s)
        if (!w_rst_s) begin
            r_cand              <= '0;
            r_cnt               <= '0;
            ltssm_state         <= '0;
            link_up             <= 1'b0;
            state_change_p      <= 1'b0;
            hotreset_entry_p    <= 1'b0;
            disabled_entry_p    <= 1'b0;
            detectquiet_entry_p <= 1'b0;
            l0_entry_p          <= 1'b0;
            hotreset_count      <= '0;
        end else begin
            if (w_valid && !w_match) begin
                r_cand <= r_ltssm_s;
                r_cnt  <= 4'd1;
            end else if (w_valid && r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_commit) begin
                ltssm_state <= r_cand;
                link_up     <= r_cand == LTSSM_L0;
            end
            state_change_p      <= w_commit;
            hotreset_entry_p    <= w_commit && r_cand == HOTRESET;
            disabled_entry_p    <= w_commit && r_cand == DISABLED;
            detectquiet_entry_p <= w_commit && r_cand == DETECTQUIET;
            l0_entry_p          <= w_commit && r_cand == LTSSM_L0;
            if (w_commit && r_cand == HOTRESET && hotreset_count != 8'hFF)
                hotreset_count <= hotreset_count + 8'd1;
        end
endmodule

// File: tb/tb_coreresetp_ltssm_monitor.sv
// tb_coreresetp_ltssm_monitor: vector table plus scoreboard of expected commits for the LTSSM monitor.
`timescale 1ns/100ps
module tb_coreresetp_ltssm_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, pwrite;
    logic [31:0] prdata;
    logic [4:0]  ltssm_state;
    logic        state_change_p, hotreset_entry_p, disabled_entry_p, detectquiet_entry_p, l0_entry_p;
    logic        link_up;
    logic [7:0]  hotreset_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] val;
        logic       psel;
        logic       pwrite;
        int         hold;
        logic       commit;
        logic [3:0] mask;
        logic [4:0] st;
        logic       link;
        logic [7:0] hc;
    } vec_t;

    typedef struct {
        int         due;
        logic [4:0] st;
        logic [3:0] mask;
    } exp_t;

    vec_t rows [14];
    exp_t sb [$];

    coreresetp_ltssm_monitor dut (
        .CLK_LTSSM           (clk),
        .sdif_core_reset_n_0 (rst_n),
        .psel                (psel),
        .pwrite              (pwrite),
        .prdata              (prdata),
        .ltssm_state         (ltssm_state),
        .state_change_p      (state_change_p),
        .hotreset_entry_p    (hotreset_entry_p),
        .disabled_entry_p    (disabled_entry_p),
        .detectquiet_entry_p (detectquiet_entry_p),
        .l0_entry_p          (l0_entry_p),
        .link_up             (link_up),
        .hotreset_count      (hotreset_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic s, input logic w);
        logic [31:0] d;
        d = $urandom;
        d[30:26] = v;
        prdata = d;
        psel = s;
        pwrite = w;
    endtask

    task automatic expect_commit(input int due, input logic [4:0] st, input logic [3:0] mask);
        exp_t e;
        e.due = due;
        e.st = st;
        e.mask = mask;
        sb.push_back(e);
    endtask

    // Every pulse must match the oldest expected commit, at exactly its cycle.
    logic [4:0] obs;
    exp_t       cur;
    always @(negedge clk) begin
        obs = {state_change_p, hotreset_entry_p, disabled_entry_p, detectquiet_entry_p, l0_entry_p};
        if (obs != 5'b0) begin
            if (sb.size() == 0)
                chk("unexpected_pulse", 32'(obs), 32'h0);
            else begin
                cur = sb.pop_front();
                chk("commit_cycle", cyc, cur.due);
                chk("commit_outputs", {21'b0, obs, ltssm_state, link_up},
                    {21'b0, 1'b1, cur.mask, cur.st, cur.st == 5'b01111});
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            chk("missed_commit", cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    initial begin
        rows[0]  = '{5'b01111, 1'b0, 1'b0, 8, 1'b1, 4'b0001, 5'b01111, 1'b1, 8'd0};
        rows[1]  = '{5'b01111, 1'b0, 1'b0, 4, 1'b0, 4'b0000, 5'b01111, 1'b1, 8'd0};
        rows[2]  = '{5'b10100, 1'b0, 1'b0, 8, 1'b1, 4'b1000, 5'b10100, 1'b0, 8'd1};
        rows[3]  = '{5'b10000, 1'b0, 1'b0, 8, 1'b1, 4'b0100, 5'b10000, 1'b0, 8'd1};
        rows[4]  = '{5'b00000, 1'b0, 1'b0, 8, 1'b1, 4'b0010, 5'b00000, 1'b0, 8'd1};
        rows[5]  = '{5'b10100, 1'b0, 1'b0, 2, 1'b0, 4'b0000, 5'b00000, 1'b0, 8'd1};
        rows[6]  = '{5'b10000, 1'b0, 1'b0, 2, 1'b0, 4'b0000, 5'b00000, 1'b0, 8'd1};
        rows[7]  = '{5'b10100, 1'b0, 1'b0, 2, 1'b0, 4'b0000, 5'b00000, 1'b0, 8'd1};
        rows[8]  = '{5'b10000, 1'b0, 1'b0, 2, 1'b0, 4'b0000, 5'b00000, 1'b0, 8'd1};
        rows[9]  = '{5'b01111, 1'b0, 1'b0, 8, 1'b1, 4'b0001, 5'b01111, 1'b1, 8'd1};
        rows[10] = '{5'b00000, 1'b0, 1'b0, 8, 1'b1, 4'b0010, 5'b00000, 1'b0, 8'd1};
        rows[11] = '{5'b10000, 1'b1, 1'b1, 8, 1'b1, 4'b0100, 5'b10000, 1'b0, 8'd1};
        rows[12] = '{5'b10100, 1'b1, 1'b0, 8, 1'b0, 4'b0000, 5'b10000, 1'b0, 8'd1};
        rows[13] = '{5'b10100, 1'b0, 1'b0, 8, 1'b1, 4'b1000, 5'b10100, 1'b0, 8'd2};

        rst_n = 1'b0;
        psel = 1'b0;
        pwrite = 1'b0;
        prdata = '0;
        #1;
        chk("reset_state", {27'b0, ltssm_state}, 32'h0);
        chk("reset_link", {31'b0, link_up}, 32'h0);
        chk("reset_hc", {24'b0, hotreset_count}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_dq_state", {27'b0, ltssm_state}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            drive(rows[i].val, rows[i].psel, rows[i].pwrite);
            if (rows[i].commit)
                expect_commit(cyc + 5, rows[i].val, rows[i].mask);
            repeat (rows[i].hold) @(negedge clk);
            chk($sformatf("row%0d_state", i), {27'b0, ltssm_state}, {27'b0, rows[i].st});
            chk($sformatf("row%0d_link", i), {31'b0, link_up}, {31'b0, rows[i].link});
            chk($sformatf("row%0d_hc", i), {24'b0, hotreset_count}, {24'b0, rows[i].hc});
        end

        // 1 ns reset glitch in the middle of debouncing L0
        drive(5'b01111, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        chk("glitch_state", {27'b0, ltssm_state}, 32'h0);
        chk("glitch_hc", {24'b0, hotreset_count}, 32'h0);
        chk("glitch_link", {31'b0, link_up}, 32'h0);
        #0.5 rst_n = 1'b1;
        expect_commit(cyc + 7, 5'b01111, 4'b0001);
        @(negedge clk);
        repeat (9) @(negedge clk);
        chk("glitch_commit_state", {27'b0, ltssm_state}, 32'h0F);

        // APB read interrupts debounce: count resumes rather than restarting
        drive(5'b10100, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            prdata = $urandom;
            psel = 1'b1;
            pwrite = 1'b0;
            @(negedge clk);
        end
        drive(5'b10100, 1'b0, 1'b0);
        expect_commit(cyc + 4, 5'b10100, 4'b1000);
        repeat (8) @(negedge clk);
        chk("apb_hold_state", {27'b0, ltssm_state}, 32'h14);
        chk("apb_hold_hc", {24'b0, hotreset_count}, 32'h1);

        for (int i = 0; i < 300; i++) begin
            drive(5'b00000, 1'b0, 1'b0);
            expect_commit(cyc + 5, 5'b00000, 4'b0010);
            repeat (6) @(negedge clk);
            drive(5'b10100, 1'b0, 1'b0);
            expect_commit(cyc + 5, 5'b10100, 4'b1000);
            repeat (6) @(negedge clk);
            if (i == 99)
                chk("hc_midway", {24'b0, hotreset_count}, 32'd101);
        end
        chk("hc_saturated", {24'b0, hotreset_count}, 32'hFF);
        repeat (4) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
